// File: rtl/dekatron_pkg.sv
// rtl/dekatron_pkg.sv - shared types and defaults for the dekatron carry chain
package dekatron_pkg;

    typedef enum logic [1:0] {
        CS_NONE = 2'd0,
        CS_LOW  = 2'd1,
        CS_HIGH = 2'd2
    } carry_state_t;

    localparam int DEKATRON_POSITIONS = 10;

endpackage

// File: rtl/dekatron_carry_digit.sv
// rtl/dekatron_carry_digit.sv - per-digit endpoint tracker with carry/borrow pend and error flags
module dekatron_carry_digit
    import dekatron_pkg::*;
#(
    parameter int POSITIONS = DEKATRON_POSITIONS
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [POSITIONS-1:0] Sense,
    input  logic                 CarryAck,
    input  logic                 BorrowAck,
    output logic                 CarryLow,
    output logic                 CarryHigh,
    output logic                 CarryPend,
    output logic                 BorrowPend,
    output logic                 FwdWrap,
    output logic                 BwdWrap,
    output logic                 Error
);

    localparam logic [POSITIONS-1:0] ONE = POSITIONS'(1);

    carry_state_t state;
    carry_state_t nextState;
    logic         senseZero;
    logic         senseMulti;
    logic         overrun;

    // An all-dark tube means the glow is in transit between cathodes; more
    // than one lit cathode is physically impossible and flagged as an error.
    assign senseZero  = (Sense == '0);
    assign senseMulti = |(Sense & (Sense - ONE));

    // Classify the current sample; transit and illegal samples keep the old state.
    always_comb begin
        nextState = state;
        if (!senseZero && !senseMulti) begin
            if (Sense[0]) begin
                nextState = CS_LOW;
            end else if (Sense[POSITIONS-1]) begin
                nextState = CS_HIGH;
            end else begin
                nextState = CS_NONE;
            end
        end
    end

    // Only endpoint-to-endpoint moves count as wraps; leaving NONE never does.
    assign FwdWrap = (state == CS_HIGH) && (nextState == CS_LOW);
    assign BwdWrap = (state == CS_LOW)  && (nextState == CS_HIGH);

    assign overrun = (FwdWrap && CarryPend  && !CarryAck) ||
                     (BwdWrap && BorrowPend && !BorrowAck);

    assign CarryLow  = (state == CS_LOW);
    assign CarryHigh = (state == CS_HIGH);

    // State, pend flags and sticky error; a new wrap always wins over an ack.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= CS_NONE;
            CarryPend  <= 1'b0;
            BorrowPend <= 1'b0;
            Error      <= 1'b0;
        end else begin
            state <= nextState;

            if (FwdWrap) begin
                CarryPend <= 1'b1;
            end else if (CarryAck) begin
                CarryPend <= 1'b0;
            end

            if (BwdWrap) begin
                BorrowPend <= 1'b1;
            end else if (BorrowAck) begin
                BorrowPend <= 1'b0;
            end

            if (senseMulti || overrun) begin
                Error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dekatron_carry_chain.sv
// rtl/dekatron_carry_chain.sv - multi-digit dekatron carry monitor with overflow and all-low flags
module dekatron_carry_chain
    import dekatron_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int POSITIONS = DEKATRON_POSITIONS
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic [DIGITS-1:0][POSITIONS-1:0]   In,
    input  logic [DIGITS-1:0]                  CarryAck,
    input  logic [DIGITS-1:0]                  BorrowAck,
    output logic [DIGITS-1:0]                  CarryLow,
    output logic [DIGITS-1:0]                  CarryHigh,
    output logic [DIGITS-1:0]                  CarryPend,
    output logic [DIGITS-1:0]                  BorrowPend,
    output logic                               Overflow,
    output logic                               Underflow,
    output logic                               AllLow,
    output logic [DIGITS-1:0]                  Error
);

    logic [DIGITS-1:0] fwdWrap;
    logic [DIGITS-1:0] bwdWrap;

    for (genvar d = 0; d < DIGITS; d++) begin : gDigit
        dekatron_carry_digit #(
            .POSITIONS (POSITIONS)
        ) uDigit (
            .Clk        (Clk),
            .Rst        (Rst),
            .Sense      (In[d]),
            .CarryAck   (CarryAck[d]),
            .BorrowAck  (BorrowAck[d]),
            .CarryLow   (CarryLow[d]),
            .CarryHigh  (CarryHigh[d]),
            .CarryPend  (CarryPend[d]),
            .BorrowPend (BorrowPend[d]),
            .FwdWrap    (fwdWrap[d]),
            .BwdWrap    (bwdWrap[d]),
            .Error      (Error[d])
        );
    end

    // Chain-level flags: top-digit wrap pulses share the pend-set edge, AllLow lags the states by one.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
            AllLow    <= 1'b0;
        end else begin
            Overflow  <= fwdWrap[DIGITS-1];
            Underflow <= bwdWrap[DIGITS-1];
            AllLow    <= &CarryLow;
        end
    end

endmodule

// File: doc/dekatron_carry_chain.md
DEKATRON_CARRY_CHAIN -- requirements
Module: dekatron_carry_chain

Interface
REQ-001 Parameter DIGITS, default 4, number of dekatron digits monitored (1..16).
REQ-002 Parameter POSITIONS, default 10, cathode positions per digit (3..16).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 In  input  DIGITS x POSITIONS  per-digit cathode sense, already synchronous to Clk.
REQ-006 CarryAck  input  DIGITS  per-digit acknowledge of pending carry.
REQ-007 BorrowAck  input  DIGITS  per-digit acknowledge of pending borrow.
REQ-008 CarryLow  output  DIGITS  digit d state is LOW (last valid position was 0).
REQ-009 CarryHigh  output  DIGITS  digit d state is HIGH (last valid position was POSITIONS-1).
REQ-010 CarryPend  output  DIGITS  forward wrap of digit d awaiting CarryAck.
REQ-011 BorrowPend  output  DIGITS  backward wrap of digit d awaiting BorrowAck.
REQ-012 Overflow  output  1  one-cycle pulse on forward wrap of digit DIGITS-1.
REQ-013 Underflow  output  1  one-cycle pulse on backward wrap of digit DIGITS-1.
REQ-014 AllLow  output  1  every digit in LOW state.
REQ-015 Error  output  DIGITS  sticky: illegal sense pattern or pending overrun on digit d.

Function
REQ-016 Each digit SHALL hold a state in {NONE, LOW, HIGH}; CarryLow/CarryHigh are registered decodes of it.
REQ-017 Sample classes per digit: only bit 0 -> LOW; only bit POSITIONS-1 -> HIGH; exactly one middle bit -> NONE; all zero (glow in transit) -> hold; two or more bits -> hold and set Error[d].
REQ-018 State SHALL update on the edge following the sample; output latency one cycle from In.
REQ-019 HIGH->LOW transition (direct, or via any number of all-zero cycles) SHALL be a forward wrap; LOW->HIGH likewise a backward wrap; NONE->LOW and NONE->HIGH SHALL NOT be wraps.
REQ-020 Forward wrap SHALL set CarryPend[d] on the same edge the state becomes LOW; backward wrap SHALL set BorrowPend[d] on the edge the state becomes HIGH.
REQ-021 CarryPend[d] SHALL clear on the edge where CarryAck[d]=1 and no new forward wrap occurs; BorrowPend likewise with BorrowAck.
REQ-022 Wrap and Ack in the same cycle: pend stays 1, no Error.
REQ-023 Wrap while pend already 1 and no Ack: pend stays 1, Error[d] set (overrun).
REQ-024 Ack with pend=0 SHALL be ignored.
REQ-025 Overflow/Underflow SHALL pulse high for exactly one cycle, aligned with the top digit's pend set edge, independent of its Ack.
REQ-026 AllLow SHALL be registered, asserted one cycle after all digits' states are LOW.
REQ-027 Error[d] SHALL clear only on reset.
REQ-028 Digits SHALL be independent; no combinational path from In or Ack to any output.

Reset
REQ-029 While Rst=1: all states NONE; CarryLow, CarryHigh, CarryPend, BorrowPend, Error = 0; Overflow, Underflow, AllLow = 0.
REQ-030 Reset SHALL override In and Ack in the same cycle; a wrap in progress during reset is discarded.
REQ-031 After Rst falls, first valid In sample SHALL set state without generating a wrap.

Structure
REQ-032 Package dekatron_pkg SHALL hold carry_state_t enum {CS_NONE, CS_LOW, CS_HIGH} and default DEKATRON_POSITIONS = 10.
REQ-033 Per-digit logic SHALL be one sub-module dekatron_carry_digit, instantiated DIGITS times by generate; the top adds Overflow/Underflow/AllLow.

Verification
REQ-034 Reset, then In[0] steps 0..9,0 one position per cycle -> CarryHigh[0]=1 after 9, CarryPend[0]=1 after 0, Overflow silent (DIGITS=4).
REQ-035 Digit 3 sequence 9, 0x000, 0 -> CarryPend[3]=1 and Overflow single-cycle pulse; digit 3 sequence 0, 9 -> BorrowPend[3]=1, Underflow pulse.
REQ-036 CarryPend[1]=1, second wrap with CarryAck[1]=1 same cycle -> pend 1, Error[1]=0; third wrap with no Ack -> Error[1]=1 sticky.
REQ-037 In[2]=0x201 (bits 0 and 9) -> state held, Error[2]=1; then Rst pulse -> all outputs 0.
REQ-038 All digits at position 0 -> AllLow=1 one cycle later; digit 0 moves to 5 -> AllLow=0.
REQ-039 Reset asserted mid-wrap (state HIGH, In=0) then In=0 after release -> no CarryPend, state LOW.
